// File: rtl/pattern_detect_ctrl_if.sv
// Configuration handshake, run control, serial data and status bundle
// for pattern_detect_ctrl.
interface pattern_detect_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_limit;
  logic             cfg_ready;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             z;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_limit, start, abort, x, x_valid,
    input  cfg_ready, z, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_limit, start, abort, x, x_valid,
    output cfg_ready, z, match_count, busy, done
  );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Serial overlapping pattern detector with configurable pattern and match
// limit, sequenced by an IDLE/ARMED/RUN/DONE controller.
module pattern_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  pattern_detect_ctrl_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t             state;
  logic [PAT_W-1:0]   pattern;
  logic [CNT_W-1:0]   limit;
  logic [PAT_W-2:0]   history;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   count;
  logic [PAT_W-1:0]   window;
  logic [CNT_W-1:0]   count_inc;
  logic               hit;

  assign window    = {history, bus.x};
  assign hit       = (state == RUN) && bus.x_valid && (fill == FILL_MAX) &&
                     (window == pattern);
  assign count_inc = (count == '1) ? count : count + 1'b1;

  assign bus.z           = hit;
  assign bus.match_count = count;
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.cfg_ready   = (state == IDLE) || (state == ARMED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pattern <= '0;
      limit   <= '0;
      history <= '0;
      fill    <= '0;
      count   <= '0;
    end else if (bus.abort) begin
      // Abort outranks start, cfg and a same-cycle match; config is retained.
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            pattern <= bus.cfg_pattern;
            limit   <= bus.cfg_limit;
            state   <= ARMED;
          end
        end
        ARMED: begin
          if (bus.cfg_valid) begin
            pattern <= bus.cfg_pattern;
            limit   <= bus.cfg_limit;
          end
          if (bus.start) begin
            state   <= RUN;
            history <= '0;
            fill    <= '0;
            count   <= '0;
          end
        end
        RUN: begin
          if (bus.x_valid) begin
            history <= window[PAT_W-2:0];
            if (fill != FILL_MAX) fill <= fill + 1'b1;
          end
          if (hit) begin
            count <= count_inc;
            if ((limit != '0) && (count_inc == limit)) state <= DONE;
          end
        end
        DONE: begin
          if (bus.start) begin
            state   <= RUN;
            history <= '0;
            fill    <= '0;
            count   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
